// File: rtl/image_pingpong_buffer.sv
// Double-buffered image store: one bank fills from the pixel stream while the
// other bank streams a completed image out over a valid/ready handshake.
module image_pingpong_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_PIXELS = 784,
  parameter int ADDR_WIDTH   = $clog2(IMAGE_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  image_written,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_index,
  output logic                  rd_last,
  output logic [1:0]            bank_full,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMAGE_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   BANK_OFS = (ADDR_WIDTH + 1)'(IMAGE_PIXELS);

  typedef enum logic {R_IDLE = 1'b0, R_STREAM = 1'b1} rd_state_e;

  logic [DATA_WIDTH-1:0] mem_q [0:2*IMAGE_PIXELS-1];

  rd_state_e             state_q, state_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  image_written_q, image_written_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_index_q, rd_index_d;
  logic                  rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  wr_ready_s, wr_accept_s, rd_beat_s;
  logic                  rd_issue_s, rd_issue_bank_s;
  logic [ADDR_WIDTH-1:0] rd_issue_idx_s;
  logic [ADDR_WIDTH:0]   wr_addr_s, rd_addr_s;

  // Ready depends only on registered bank status, so a bank freed this cycle is writable next cycle.
  assign wr_ready_s  = ~bank_full_q[wr_bank_q];
  assign wr_accept_s = wr_valid & wr_ready_s & ~clear;
  assign rd_beat_s   = rd_valid_q & rd_ready;
  assign wr_addr_s   = {1'b0, wr_cnt_q} + (wr_bank_q ? BANK_OFS : {(ADDR_WIDTH + 1){1'b0}});
  assign rd_addr_s   = {1'b0, rd_issue_idx_s} + (rd_issue_bank_s ? BANK_OFS : {(ADDR_WIDTH + 1){1'b0}});

  // Write counter, bank status and read FSM next-state logic.
  always_comb begin
    state_d         = state_q;
    bank_full_d     = bank_full_q;
    wr_bank_d       = wr_bank_q;
    wr_cnt_d        = wr_cnt_q;
    rd_bank_d       = rd_bank_q;
    image_written_d = 1'b0;
    overflow_d      = overflow_q | (wr_valid & ~wr_ready_s);
    rd_valid_d      = rd_valid_q;
    rd_index_d      = rd_index_q;
    rd_last_d       = rd_last_q;
    rd_issue_s      = 1'b0;
    rd_issue_bank_s = rd_bank_q;
    rd_issue_idx_s  = {ADDR_WIDTH{1'b0}};

    if (wr_accept_s) begin
      if (wr_cnt_q == LAST_IDX) begin
        wr_cnt_d               = {ADDR_WIDTH{1'b0}};
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        image_written_d        = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    // In R_STREAM rd_valid is always high, so a beat is the only thing that frees the output slot.
    case (state_q)
      R_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          rd_issue_s = 1'b1;
          state_d    = R_STREAM;
        end else begin
          state_d = R_IDLE;
        end
      end
      R_STREAM: begin
        if (rd_beat_s && rd_last_q) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = ~rd_bank_q;
          if (bank_full_q[~rd_bank_q]) begin
            rd_issue_s      = 1'b1;
            rd_issue_bank_s = ~rd_bank_q;
          end else begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            state_d    = R_IDLE;
          end
        end else if (rd_beat_s) begin
          rd_issue_s     = 1'b1;
          rd_issue_idx_s = rd_index_q + 1'b1;
        end else begin
          state_d = R_STREAM;
        end
      end
      default: state_d = R_IDLE;
    endcase

    if (rd_issue_s) begin
      rd_valid_d = 1'b1;
      rd_index_d = rd_issue_idx_s;
      rd_last_d  = (rd_issue_idx_s == LAST_IDX);
    end else begin
      rd_index_d = rd_index_q;
    end
  end

  // Control and output registers; clear returns them to their reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= R_IDLE;
      bank_full_q     <= 2'b00;
      wr_bank_q       <= 1'b0;
      wr_cnt_q        <= {ADDR_WIDTH{1'b0}};
      rd_bank_q       <= 1'b0;
      image_written_q <= 1'b0;
      overflow_q      <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_index_q      <= {ADDR_WIDTH{1'b0}};
      rd_last_q       <= 1'b0;
      rd_data_q       <= {DATA_WIDTH{1'b0}};
    end else if (clear) begin
      state_q         <= R_IDLE;
      bank_full_q     <= 2'b00;
      wr_bank_q       <= 1'b0;
      wr_cnt_q        <= {ADDR_WIDTH{1'b0}};
      rd_bank_q       <= 1'b0;
      image_written_q <= 1'b0;
      overflow_q      <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_index_q      <= {ADDR_WIDTH{1'b0}};
      rd_last_q       <= 1'b0;
      rd_data_q       <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q         <= state_d;
      bank_full_q     <= bank_full_d;
      wr_bank_q       <= wr_bank_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_bank_q       <= rd_bank_d;
      image_written_q <= image_written_d;
      overflow_q      <= overflow_d;
      rd_valid_q      <= rd_valid_d;
      rd_index_q      <= rd_index_d;
      rd_last_q       <= rd_last_d;
      if (rd_issue_s) begin
        rd_data_q <= mem_q[rd_addr_s];
      end
    end
  end

  // Pixel storage; left without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_q[wr_addr_s] <= wr_data;
    end
  end

  assign wr_ready      = wr_ready_s;
  assign image_written = image_written_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_index      = rd_index_q;
  assign rd_last       = rd_last_q;
  assign bank_full     = bank_full_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_image_pingpong_buffer.sv
// Directed bench: a default-size instance for the full 784-pixel image and a
// 16-pixel instance for ping-pong, backpressure, full, clear and reset cases.
module tb_image_pingpong_buffer;

  logic clk;
  logic rst;

  logic       a_clear, a_wr_valid, a_wr_ready, a_image_written, a_rd_valid, a_rd_ready, a_rd_last, a_overflow;
  logic [7:0] a_wr_data, a_rd_data;
  logic [9:0] a_rd_index;
  logic [1:0] a_bank_full;

  logic       b_clear, b_wr_valid, b_wr_ready, b_image_written, b_rd_valid, b_rd_ready, b_rd_last, b_overflow;
  logic [7:0] b_wr_data, b_rd_data;
  logic [3:0] b_rd_index;
  logic [1:0] b_bank_full;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] pix_a [784];
  logic [7:0] exp_q [$];
  logic [7:0] exp_v, hold_data;
  logic [3:0] hold_idx;
  bit         stall_hold = 1'b0;
  bit         mon_en = 1'b0;
  int         exp_idx = 0, beats = 0, gaps = 0, beat_target = 0;
  int         extra_beats = 0, write_timeouts = 0, a_iw_cnt = 0;
  int         guard;
  logic       prev_ready;

  image_pingpong_buffer u_dut_a (
    .clk(clk), .rst(rst), .clear(a_clear),
    .wr_valid(a_wr_valid), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .image_written(a_image_written),
    .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
    .rd_index(a_rd_index), .rd_last(a_rd_last),
    .bank_full(a_bank_full), .overflow(a_overflow)
  );

  image_pingpong_buffer #(.DATA_WIDTH(8), .IMAGE_PIXELS(16), .ADDR_WIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .clear(b_clear),
    .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .image_written(b_image_written),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
    .rd_index(b_rd_index), .rd_last(b_rd_last),
    .bank_full(b_bank_full), .overflow(b_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producer for the small instance: only presents a pixel while the bank can take it.
  task automatic b_write(input int n);
    logic [7:0] v;
    int g;
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom_range(0, 255));
      g = 0;
      while (!b_wr_ready && g < 200) begin
        b_wr_valid = 1'b0;
        tick();
        g++;
      end
      if (g >= 200) write_timeouts++;
      b_wr_valid = 1'b1;
      b_wr_data  = v;
      tick();
      exp_q.push_back(v);
    end
    b_wr_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string tag);
    int g;
    g = 0;
    while (beats < target && g < 200) begin
      tick();
      g++;
    end
    check_eq({tag, "_beats"}, beats, target);
    check_eq({tag, "_left"}, exp_q.size(), 0);
  endtask

  // Read-side scoreboard for the small instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (a_image_written) a_iw_cnt++;
    if (!mon_en || rst || b_clear) begin
      stall_hold = 1'b0;
    end else if (b_rd_valid) begin
      if (stall_hold) begin
        check_eq("b_stall_data", b_rd_data, hold_data);
        check_eq("b_stall_idx", b_rd_index, hold_idx);
      end
      if (b_rd_ready) begin
        stall_hold = 1'b0;
        if (exp_q.size() == 0) begin
          extra_beats++;
        end else begin
          exp_v = exp_q.pop_front();
          check_eq("b_data", b_rd_data, exp_v);
          check_eq("b_idx", b_rd_index, exp_idx);
          check_eq("b_last", b_rd_last, (exp_idx == 15));
          exp_idx = (exp_idx == 15) ? 0 : exp_idx + 1;
          beats++;
        end
      end else begin
        stall_hold = 1'b1;
        hold_data  = b_rd_data;
        hold_idx   = b_rd_index;
      end
    end else begin
      stall_hold = 1'b0;
      if (beats > 0 && beats < beat_target) gaps++;
    end
  end

  initial begin
    rst = 1'b1;
    a_clear = 1'b0; a_wr_valid = 1'b0; a_wr_data = 8'h00; a_rd_ready = 1'b1;
    b_clear = 1'b0; b_wr_valid = 1'b0; b_wr_data = 8'h00; b_rd_ready = 1'b0;
    for (int i = 0; i < 784; i++) pix_a[i] = 8'($urandom_range(0, 255));

    #23;
    check_eq("rst_b_valid", b_rd_valid, 1'b0);
    check_eq("rst_b_full", b_bank_full, 2'b00);
    check_eq("rst_b_ovf", b_overflow, 1'b0);
    check_eq("rst_b_iw", b_image_written, 1'b0);
    check_eq("rst_b_idx", b_rd_index, 4'd0);
    check_eq("rst_b_data", b_rd_data, 8'h00);
    check_eq("rst_b_last", b_rd_last, 1'b0);
    check_eq("rst_b_wr_ready", b_wr_ready, 1'b1);
    check_eq("rst_a_valid", a_rd_valid, 1'b0);
    check_eq("rst_a_wr_ready", a_wr_ready, 1'b1);
    #4 rst = 1'b0;
    tick();

    // Full-size image, back-to-back writes, consumer always ready.
    for (int i = 0; i < 784; i++) begin
      a_wr_valid = 1'b1;
      a_wr_data  = pix_a[i];
      if (i == 0 || i == 783) check_eq("a_wr_ready", a_wr_ready, 1'b1);
      tick();
    end
    a_wr_valid = 1'b0;
    check_eq("a_iw_pulse", a_image_written, 1'b1);
    check_eq("a_valid_early", a_rd_valid, 1'b0);
    check_eq("a_full", a_bank_full, 2'b01);
    tick();
    check_eq("a_iw_drop", a_image_written, 1'b0);
    for (int i = 0; i < 784; i++) begin
      check_eq("a_valid", a_rd_valid, 1'b1);
      check_eq("a_data", a_rd_data, pix_a[i]);
      check_eq("a_idx", a_rd_index, i);
      check_eq("a_last", a_rd_last, (i == 783));
      tick();
    end
    check_eq("a_done_valid", a_rd_valid, 1'b0);
    check_eq("a_done_full", a_bank_full, 2'b00);
    check_eq("a_iw_count", a_iw_cnt, 1);

    // Ping-pong: three images; only the third waits for its bank, leaving a single bubble.
    mon_en = 1'b1;
    b_rd_ready = 1'b1;
    beats = 0; exp_idx = 0; gaps = 0; beat_target = 48;
    b_write(48);
    wait_beats(48, "b_pp");
    check_eq("b_pp_gaps", gaps, 1);
    check_eq("b_pp_ovf", b_overflow, 1'b0);
    check_eq("b_pp_full", b_bank_full, 2'b00);
    beat_target = 0;

    // Backpressure: five stalled cycles, then rd_ready toggles every cycle.
    b_rd_ready = 1'b0;
    beats = 0; exp_idx = 0;
    b_write(16);
    guard = 0;
    while (!b_rd_valid && guard < 20) begin tick(); guard++; end
    check_eq("b_bp_valid", b_rd_valid, 1'b1);
    repeat (5) tick();
    for (int k = 0; k < 64 && beats < 16; k++) begin
      b_rd_ready = ~b_rd_ready;
      tick();
    end
    wait_beats(16, "b_bp");

    // Both banks full with the consumer stalled.
    b_rd_ready = 1'b0;
    beats = 0; exp_idx = 0;
    b_write(32);
    check_eq("b_bf_full", b_bank_full, 2'b11);
    check_eq("b_bf_ready", b_wr_ready, 1'b0);
    check_eq("b_bf_ovf_pre", b_overflow, 1'b0);
    b_wr_valid = 1'b1;
    b_wr_data  = 8'hA5;
    tick();
    check_eq("b_bf_ovf", b_overflow, 1'b1);
    check_eq("b_bf_ready2", b_wr_ready, 1'b0);
    b_rd_ready = 1'b1;
    guard = 0;
    prev_ready = b_wr_ready;
    while (b_bank_full[0] && guard < 100) begin
      prev_ready = b_wr_ready;
      tick();
      guard++;
    end
    b_wr_valid = 1'b0;
    check_eq("b_bf_drain", b_bank_full, 2'b10);
    check_eq("b_bf_prev_ready", prev_ready, 1'b0);
    check_eq("b_bf_ready_back", b_wr_ready, 1'b1);
    wait_beats(32, "b_bf");
    check_eq("b_bf_ovf_sticky", b_overflow, 1'b1);

    // Clear while bank 0 streams and bank 1 is partly written.
    b_rd_ready = 1'b0;
    beats = 0; exp_idx = 0;
    b_write(16);
    b_write(7);
    check_eq("b_cl_pre_valid", b_rd_valid, 1'b1);
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    check_eq("b_cl_valid", b_rd_valid, 1'b0);
    check_eq("b_cl_full", b_bank_full, 2'b00);
    check_eq("b_cl_ovf", b_overflow, 1'b0);
    check_eq("b_cl_wr_ready", b_wr_ready, 1'b1);
    check_eq("b_cl_idx", b_rd_index, 4'd0);
    exp_q.delete();
    beats = 0; exp_idx = 0;
    b_rd_ready = 1'b1;
    b_write(16);
    wait_beats(16, "b_cl");

    // Asynchronous reset in the middle of a stream.
    beats = 0; exp_idx = 0;
    b_write(16);
    guard = 0;
    while (beats < 5 && guard < 50) begin tick(); guard++; end
    #2 rst = 1'b1;
    #1;
    check_eq("ar_valid", b_rd_valid, 1'b0);
    check_eq("ar_full", b_bank_full, 2'b00);
    check_eq("ar_idx", b_rd_index, 4'd0);
    check_eq("ar_data", b_rd_data, 8'h00);
    check_eq("ar_last", b_rd_last, 1'b0);
    check_eq("ar_wr_ready", b_wr_ready, 1'b1);
    #8 rst = 1'b0;
    exp_q.delete();
    beats = 0; exp_idx = 0;
    tick();
    b_write(16);
    wait_beats(16, "ar_resume");

    check_eq("b_extra_beats", extra_beats, 0);
    check_eq("b_write_timeouts", write_timeouts, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
